// File: rtl/hw_indicator_mc.sv
// -----------------------------------------------------------------------------
// hw_indicator_mc
//
// Multi-channel LED status indicator. Each of N_CH channels holds its own
// run-time configuration (mode, burst count, PWM brightness, half-period)
// loaded through a single-cycle register-write port, and drives one LED.
// Modes: OFF, ON, BLINK, BURST, ONESHOT. A shared prescaler produces the
// millisecond-style timebase tick; a shared 8-bit PWM counter sets brightness.
//
// Ports
//   iCLK    in   1     clock
//   iRST_n  in   1     asynchronous active-low reset
//   iWR     in   1     config write strobe (one cycle per write)
//   iADDR   in   AW    channel index for the write (>= N_CH is ignored)
//   iWDATA  in   32    config word: [2:0] mode, [7:4] burst N, [15:8] B,
//                      [31:16] half-period H in ticks
//   iTRIG   in   N_CH  per-channel oneshot trigger, level-sampled
//   oLED    out  N_CH  registered LED drive, 1 = lit
//   oBUSY   out  N_CH  1 while a ONESHOT pulse or BURST ON/OFF part is active
// -----------------------------------------------------------------------------
module hw_indicator_mc #(
  parameter int CLK_FREQ = 128000000,
  parameter int TICK_HZ  = 1000,
  parameter int N_CH     = 4,
  parameter int AW       = 2
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  input  logic            iWR,
  input  logic [AW-1:0]   iADDR,
  input  logic [31:0]     iWDATA,
  input  logic [N_CH-1:0] iTRIG,
  output logic [N_CH-1:0] oLED,
  output logic [N_CH-1:0] oBUSY
);

  localparam int PRE_DIV = CLK_FREQ / TICK_HZ;
  localparam int PRE_W   = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;
  localparam logic [15:0] H_RESET = (TICK_HZ / 2 >= 1) ? 16'(TICK_HZ / 2) : 16'd1;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_BURST   = 3'd3,
    MODE_ONESHOT = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_ON   = 2'd1,
    PH_OFF  = 2'd2,
    PH_GAP  = 2'd3
  } phase_e;

  // ---------------------------------------------------------------------------
  // Shared timebase: prescaler tick and PWM ramp
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] preCnt;
  logic [7:0]       pwmCnt;
  logic             tick;

  assign tick = (preCnt == PRE_W'(PRE_DIV - 1));

  // NOTE: every clocked state uses non-blocking (<=) so all registers sample
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      preCnt <= '0;
      pwmCnt <= '0;
    end else begin
      preCnt <= tick ? '0 : preCnt + 1'b1;
      // Ramp 0..254 so B=255 is always above the counter (fully lit).
      pwmCnt <= (pwmCnt == 8'd254) ? 8'd0 : pwmCnt + 8'd1;
    end
  end

  // Bit 3 of the config word is reserved.
  logic unusedWdata;
  assign unusedWdata = iWDATA[3];

  // Decoded fields of the incoming write (same for every channel).
  logic [2:0] wrMode;
  logic       wrStartsOn;
  assign wrMode     = iWDATA[2:0];
  assign wrStartsOn = (wrMode == MODE_ON) || (wrMode == MODE_BLINK) ||
                      (wrMode == MODE_BURST);

  // ---------------------------------------------------------------------------
  // Per-channel configuration, phase FSM and registered outputs
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    localparam bit IS_CH0 = (ch == 0);

    logic [2:0]  mode;
    logic [3:0]  n;
    logic [7:0]  b;
    logic [15:0] h;
    phase_e      phase;
    logic [15:0] tc;
    logic [3:0]  bc;
    logic        ledQ;
    logic        busyQ;

    logic        wrHit;
    logic        trig;
    logic [15:0] hEff;
    logic [3:0]  nEff;
    logic        lastTick;

    assign wrHit    = iWR && (iADDR == AW'(ch));
    assign trig     = iTRIG[ch];
    assign hEff     = (h == 16'd0) ? 16'd1 : h;
    assign nEff     = (n == 4'd0) ? 4'd1 : n;
    // A phase ends on the tick at which tc would reach H.
    assign lastTick = tick && (tc == hEff - 16'd1);

    // NOTE: the config fields are ordinary flops (not a RAM), so they take a
    // reset value; channel 0 must come up blinking with no software help.
    always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
        mode  <= IS_CH0 ? MODE_BLINK : MODE_OFF;
        n     <= 4'd0;
        b     <= IS_CH0 ? 8'd255 : 8'd0;
        h     <= IS_CH0 ? H_RESET : 16'd0;
        phase <= IS_CH0 ? PH_ON : PH_IDLE;
        tc    <= 16'd0;
        bc    <= 4'd0;
        ledQ  <= IS_CH0;
        busyQ <= 1'b0;
      end else begin
        // Outputs follow the current phase one cycle later.
        ledQ  <= (phase == PH_ON) && (pwmCnt < b);
        busyQ <= ((mode == MODE_BURST) && ((phase == PH_ON) || (phase == PH_OFF))) ||
                 ((mode == MODE_ONESHOT) && (phase == PH_ON));

        if (wrHit) begin
          // A write wins over trigger and tick and restarts the channel.
          mode  <= wrMode;
          n     <= iWDATA[7:4];
          b     <= iWDATA[15:8];
          h     <= iWDATA[31:16];
          tc    <= 16'd0;
          bc    <= 4'd0;
          phase <= wrStartsOn ? PH_ON : PH_IDLE;
        end else begin
          case (mode)
            MODE_ON: phase <= PH_ON;

            MODE_BLINK: begin
              if (lastTick) begin
                tc    <= 16'd0;
                phase <= (phase == PH_ON) ? PH_OFF : PH_ON;
              end else if (tick) begin
                tc <= tc + 16'd1;
              end
            end

            MODE_BURST: begin
              if (lastTick) begin
                tc <= 16'd0;
                case (phase)
                  PH_ON: phase <= PH_OFF;
                  PH_OFF: begin
                    if (bc == nEff - 4'd1) begin
                      bc    <= 4'd0;
                      phase <= PH_GAP;
                    end else begin
                      bc    <= bc + 4'd1;
                      phase <= PH_ON;
                    end
                  end
                  PH_GAP: begin
                    // GAP is four H-tick segments counted in bc: exactly 4*H
                    // ticks for any H (an 18-bit span) while tc stays 16 bits.
                    if (bc == 4'd3) begin
                      bc    <= 4'd0;
                      phase <= PH_ON;
                    end else begin
                      bc <= bc + 4'd1;
                    end
                  end
                  default: phase <= PH_ON;
                endcase
              end else if (tick) begin
                tc <= tc + 16'd1;
              end
            end

            MODE_ONESHOT: begin
              if (phase == PH_IDLE) begin
                if (trig) begin
                  tc    <= 16'd0;
                  phase <= PH_ON;
                end
              end else if (phase == PH_ON) begin
                if (trig) begin
                  // Retrigger outranks the tick and extends the pulse.
                  tc <= 16'd0;
                end else if (lastTick) begin
                  tc    <= 16'd0;
                  phase <= PH_IDLE;
                end else if (tick) begin
                  tc <= tc + 16'd1;
                end
              end else begin
                phase <= PH_IDLE;
              end
            end

            // OFF and the undefined codes 5..7.
            default: phase <= PH_IDLE;
          endcase
        end
      end
    end

    assign oLED[ch]  = ledQ;
    assign oBUSY[ch] = busyQ;
  end

endmodule

// File: tb/tb_hw_indicator_mc.sv
// -----------------------------------------------------------------------------
// tb_hw_indicator_mc
//
// Self-checking bench for hw_indicator_mc with CLK_FREQ=1000, TICK_HZ=100
// (10 cycles per tick), N_CH=4, AW=3. Inputs are driven on the falling edge,
// outputs are sampled on the falling edge. A table of steady-state PWM/mode
// vectors is applied in a loop; multi-cycle behaviour (blink, burst, oneshot,
// reset) is covered by hand-written sequences measuring run lengths.
// -----------------------------------------------------------------------------
module tb_hw_indicator_mc;

  localparam bit SEL_LED  = 1'b0;
  localparam bit SEL_BUSY = 1'b1;

  logic       iCLK;
  logic       iRST_n;
  logic       iWR;
  logic [2:0] iADDR;
  logic [31:0] iWDATA;
  logic [3:0] iTRIG;
  logic [3:0] oLED;
  logic [3:0] oBUSY;

  int nTests = 0;
  int nFail  = 0;

  hw_indicator_mc #(
    .CLK_FREQ(1000),
    .TICK_HZ (100),
    .N_CH    (4),
    .AW      (3)
  ) dut (
    .iCLK  (iCLK),
    .iRST_n(iRST_n),
    .iWR   (iWR),
    .iADDR (iADDR),
    .iWDATA(iWDATA),
    .iTRIG (iTRIG),
    .oLED  (oLED),
    .oBUSY (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Steady-state vector: write channel 2, then count lit / busy cycles in a
  // 255-cycle window (one full PWM period).
  typedef struct {
    string       name;
    logic [2:0]  addr;
    logic [31:0] wdata;
    int          expLit;
    int          expBusy;
  } pwm_vec_t;

  pwm_vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    nTests++;
    if (act < lo || act > hi) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic sig(input bit busySel, input int idx);
    return busySel ? oBUSY[idx] : oLED[idx];
  endfunction

  // Number of consecutive falling-edge samples (including the current one)
  // at which the selected output equals val; capped at budget.
  task automatic run_len(input bit busySel, input int idx, input logic val,
                         input int budget, output int len);
    len = 0;
    while (sig(busySel, idx) === val && len < budget) begin
      len++;
      @(negedge iCLK);
    end
  endtask

  task automatic wait_until(input bit busySel, input int idx, input logic val,
                            input int budget, output int ok);
    int cnt = 0;
    while (sig(busySel, idx) !== val && cnt < budget) begin
      cnt++;
      @(negedge iCLK);
    end
    ok = (sig(busySel, idx) === val) ? 1 : 0;
  endtask

  task automatic count_high(input bit busySel, input int idx, input int cycles,
                            output int cnt);
    cnt = 0;
    repeat (cycles) begin
      if (sig(busySel, idx) === 1'b1) cnt++;
      @(negedge iCLK);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the write edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    iWR    = 1'b1;
    iADDR  = a;
    iWDATA = d;
    @(negedge iCLK);
    iWR    = 1'b0;
    iWDATA = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", nTests);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int cnt;
    int ok;

    //            name            addr  wdata          lit  busy
    vecs[0] = '{"on_b64",        3'd2, 32'h0001_4001,  64, 0};
    vecs[1] = '{"on_b0",         3'd2, 32'h0001_0001,   0, 0};
    vecs[2] = '{"on_b255",       3'd2, 32'h0001_FF01, 255, 0};
    vecs[3] = '{"on_b128",       3'd2, 32'h0001_8001, 128, 0};
    vecs[4] = '{"mode7_as_off",  3'd2, 32'h0001_FF07,   0, 0};
    vecs[5] = '{"oneshot_idle",  3'd2, 32'h0001_FF04,   0, 0};
    vecs[6] = '{"blink_h100_on", 3'd2, 32'h0064_FF02, 255, 0};
    vecs[7] = '{"off_b255",      3'd2, 32'h0000_FF00,   0, 0};

    iRST_n = 1'b0;
    iWR    = 1'b0;
    iADDR  = '0;
    iWDATA = '0;
    iTRIG  = '0;

    // ---------------- reset default ----------------
    repeat (3) @(negedge iCLK);
    check("rst_led", oLED, 4'b0001);
    check("rst_busy", oBUSY, 4'b0000);
    iRST_n = 1'b1;
    @(negedge iCLK);
    check("rel_led", oLED, 4'b0001);
    check("rel_busy", oBUSY, 4'b0000);
    // First tick lands 10 edges after release, 50th tick at edge 500.
    run_len(SEL_LED, 0, 1'b1, 600, len);
    check("ch0_first_high", len, 500);
    run_len(SEL_LED, 0, 1'b0, 600, len);
    check("ch0_low", len, 500);
    run_len(SEL_LED, 0, 1'b1, 600, len);
    check("ch0_high", len, 500);
    check("ch123_dark", oLED[3:1], 3'b000);

    // ---------------- BLINK ch1, H=3 ----------------
    wr(3'd1, 32'h0003_FF02);
    check("blink_write_edge", oLED[1], 1'b0);
    @(negedge iCLK);
    check("blink_lit_next", oLED[1], 1'b1);
    run_len(SEL_LED, 1, 1'b1, 40, len);
    check_range("blink_first_on", len, 21, 30);
    run_len(SEL_LED, 1, 1'b0, 40, len);
    check("blink_off", len, 30);
    run_len(SEL_LED, 1, 1'b1, 40, len);
    check("blink_on", len, 30);
    check("blink_busy", oBUSY[1], 1'b0);

    // ---------------- steady-state table on ch2 ----------------
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      repeat (2) @(negedge iCLK);
      count_high(SEL_LED, 2, 255, cnt);
      check({vecs[i].name, "_lit"}, cnt, vecs[i].expLit);
      count_high(SEL_BUSY, 2, 255, cnt);
      check({vecs[i].name, "_busy"}, cnt, vecs[i].expBusy);
    end

    // ---------------- BURST ch3, N=2, H=2 ----------------
    wr(3'd3, 32'h0002_FF23);
    @(negedge iCLK);
    check("burst_busy_start", oBUSY[3], 1'b1);
    run_len(SEL_LED, 3, 1'b1, 40, len);
    check_range("burst_first_on", len, 11, 20);
    run_len(SEL_LED, 3, 1'b0, 40, len);
    check("burst_off1", len, 20);
    run_len(SEL_LED, 3, 1'b1, 40, len);
    check("burst_on2", len, 20);
    run_len(SEL_LED, 3, 1'b0, 150, len);
    check("burst_off_gap", len, 100);
    run_len(SEL_LED, 3, 1'b1, 40, len);
    check("burst_on_rep", len, 20);
    check("burst_busy_in_off", oBUSY[3], 1'b1);
    wait_until(SEL_BUSY, 3, 1'b0, 100, ok);
    check("burst_busy_drop_seen", ok, 1);
    run_len(SEL_BUSY, 3, 1'b0, 150, len);
    check("burst_busy_gap", len, 80);
    run_len(SEL_BUSY, 3, 1'b1, 150, len);
    check("burst_busy_active", len, 80);

    // ---------------- ONESHOT ch1, H=5 ----------------
    wr(3'd1, 32'h0005_FF04);
    repeat (3) @(negedge iCLK);
    check("os_idle_led", oLED[1], 1'b0);
    check("os_idle_busy", oBUSY[1], 1'b0);
    iTRIG[1] = 1'b1;
    @(negedge iCLK);
    iTRIG[1] = 1'b0;
    check("os_trig_edge", oLED[1], 1'b0);
    @(negedge iCLK);
    check("os_busy_on", oBUSY[1], 1'b1);
    run_len(SEL_LED, 1, 1'b1, 70, len);
    check_range("os_pulse", len, 41, 50);
    check("os_busy_off", oBUSY[1], 1'b0);

    // Retrigger 30 cycles into a second pulse.
    repeat (5) @(negedge iCLK);
    iTRIG[1] = 1'b1;
    @(negedge iCLK);
    iTRIG[1] = 1'b0;
    repeat (29) @(negedge iCLK);
    check("os_still_on", oLED[1], 1'b1);
    iTRIG[1] = 1'b1;
    @(negedge iCLK);
    iTRIG[1] = 1'b0;
    @(negedge iCLK);
    run_len(SEL_LED, 1, 1'b1, 70, len);
    check_range("os_retrig_tail", len, 41, 50);

    // ---------------- out-of-range address ----------------
    wr(3'd1, 32'h0001_FF01);
    repeat (2) @(negedge iCLK);
    check("ch1_on_before", oLED[1], 1'b1);
    wr(3'd5, 32'h0000_0000);
    count_high(SEL_LED, 1, 20, cnt);
    check("addr5_ignored", cnt, 20);

    // ---------------- write and trigger in the same cycle ----------------
    iTRIG[1] = 1'b1;
    wr(3'd1, 32'h0005_FF04);
    iTRIG[1] = 1'b0;
    @(negedge iCLK);
    count_high(SEL_LED, 1, 60, cnt);
    check("wr_beats_trig_led", cnt, 0);
    count_high(SEL_BUSY, 1, 10, cnt);
    check("wr_beats_trig_busy", cnt, 0);

    // ---------------- reset mid-BURST ----------------
    wait_until(SEL_BUSY, 3, 1'b1, 300, ok);
    check("burst_active_before_rst", ok, 1);
    iRST_n = 1'b0;
    #1;
    check("midrst_led", oLED, 4'b0001);
    check("midrst_busy", oBUSY, 4'b0000);
    @(negedge iCLK);
    iRST_n = 1'b1;
    @(negedge iCLK);
    check("post_rst_led", oLED, 4'b0001);
    count_high(SEL_LED, 3, 50, cnt);
    check("post_rst_ch3_dark", cnt, 0);
    count_high(SEL_LED, 0, 50, cnt);
    check("post_rst_ch0_lit", cnt, 50);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/hw_indicator_mc.md
# hw_indicator_mc

Multi-channel, parametrised LED status indicator; the successor to the fixed-rate single-LED blinker. It drives N_CH LEDs, each independently configured at run time over a simple register-write port. Modes are OFF, ON, BLINK, BURST and ONESHOT, with per-channel PWM brightness. It sits beside the processor peripherals and shows boot, heartbeat and error status on the board LEDs.

## Interface
- CLK_FREQ, 128000000 — iCLK frequency in Hz.
- TICK_HZ, 1000 — timebase tick rate. CLK_FREQ/TICK_HZ must be an integer ≥ 2.
- N_CH, 4 — number of LED channels, 1..16.
- AW, 2 — address width, ≥ clog2(N_CH), minimum 1.
- iCLK  in  1 — clock.
- iRST_n  in  1 — reset, asynchronous, active-low. Clock is iCLK.
- iWR  in  1 — config write strobe, one cycle per write.
- iADDR  in  AW — channel index for the write.
- iWDATA  in  32 — config word:
  - [2:0] mode: 0 OFF, 1 ON, 2 BLINK, 3 BURST, 4 ONESHOT; 5–7 behave as OFF.
  - [7:4] burst count N; 0 is treated as 1.
  - [15:8] brightness B.
  - [31:16] half-period H in ticks; 0 is treated as 1.
- iTRIG  in  N_CH — per-channel oneshot trigger, level-sampled each cycle.
- oLED  out  N_CH — LED drive, registered, 1 = lit.
- oBUSY  out  N_CH — 1 while a channel's ONESHOT pulse or BURST pattern is in its active (non-gap) part.

## Operation
- **Prescaler.** Counts 0..CLK_FREQ/TICK_HZ−1. It emits a one-cycle `tick` on the wrap. It is shared by all channels.
- **PWM.** An 8-bit counter runs 0..254 and wraps. pwm_on = (pwm_cnt < B). B=0 means never lit; B=255 means always lit.
- **Per-channel state.**
  - Config register.
  - 16-bit tick counter `tc`.
  - 4-bit burst counter `bc`.
  - Phase FSM with states IDLE, ON, OFF, GAP.
- **Lit condition.** The channel is lit when phase = ON and pwm_on. oLED is that value registered.
- **Mode OFF.** FSM held in IDLE; oLED=0; oBUSY=0.
- **Mode ON.** FSM held in ON; oBUSY=0.
- **Mode BLINK.** ON for H ticks, then OFF for H ticks, repeating. oBUSY=0.
- **Mode BURST.** The sequence is (ON H, OFF H) × N, then GAP for 4·H ticks (unlit), then it repeats. oBUSY=1 in ON/OFF and 0 in GAP.
- **Mode ONESHOT.** Idle in IDLE.
  - iTRIG[ch]=1 in IDLE enters ON with tc cleared.
  - After H ticks the FSM returns to IDLE.
  - iTRIG high while in ON restarts tc (retrigger, extends the pulse).
  - A held-high iTRIG re-fires immediately on return to IDLE.
- **Phase counting.** tc increments on tick. A phase ends on the tick where tc reaches its limit; tc clears on phase change.
- **Writes.**
  - iWR with iADDR < N_CH loads that channel's config at the clock edge.
  - The same edge restarts the channel: tc=0, bc=0, phase = ON for ON/BLINK/BURST and IDLE for OFF/ONESHOT.
  - iADDR ≥ N_CH: the write is ignored and no state changes.
- **Precedence in the same cycle on the same channel:** write > trigger > tick.
- **Arithmetic.**
  - tc is 16 bits.
  - The GAP limit 4·H is computed in 18 bits, so there is no overflow at H=0xFFFF.
  - bc compares against the effective N (1..15).

## Timing
- **Reset values.**
  - Prescaler, PWM counter, all tc/bc = 0.
  - Channel 0 config: mode BLINK, B=255, H=TICK_HZ/2 (min 1), phase ON.
  - Channels 1..N_CH−1: mode OFF, phase IDLE.
  - oLED = 1 on channel 0 and 0 elsewhere, asserted during reset.
  - oBUSY = 0.
- **Reset mid-operation.** Asserting iRST_n low at any time returns all state to the reset values asynchronously. Operation resumes from the reset values on the first edge after release.
- **Output latency.** oLED and oBUSY change exactly one cycle after the internal phase/PWM change.
- **Write latency.** A write at edge k gives a new phase at k and oLED reflecting it at k+1.
- **Phase duration.** After a write or trigger, the first phase lasts between (H−1)·P+1 and H·P cycles, where P = CLK_FREQ/TICK_HZ. The jitter comes from tick alignment. Every subsequent phase lasts exactly H·P cycles.
- **Handshake.** There is no backpressure. A write is accepted every cycle iWR=1, and back-to-back writes are allowed.

## Test plan
All scenarios use CLK_FREQ=1000, TICK_HZ=100 (P=10) and N_CH=4.
- **Reset default:** release reset → oLED=4'b0001, oBUSY=0. Then oLED[0] toggles every 500 cycles (H=50); other bits stay 0.
- **BLINK:** write ch1 mode=2, H=3, B=255 → oLED[1] lit 1 cycle after the write. The first on-phase is 21–30 cycles, then exactly 30 low / 30 high periodically.
- **ON with PWM:** write ch2 mode=1, B=64 → oLED[2] high for exactly 64 of every 255 cycles. With B=0 it is never high.
- **BURST:** write ch3 mode=3, N=2, H=2 → high 20, low 20, high 20, then low 100 (20 OFF + 80 GAP), repeating. oBUSY[3] drops for the 80-cycle GAP only.
- **ONESHOT with retrigger:** ch1 mode=4, H=5.
  - A one-cycle iTRIG[1] gives oLED[1]=oBUSY[1]=1 for 41–50 cycles.
  - A second trigger 30 cycles in extends the pulse to end 41–50 cycles after the second trigger.
- **Edge cases:**
  - Write iADDR=5 (AW=3) → no output change.
  - Write and iTRIG on ch1 in the same cycle → trigger ignored, channel restarted.
  - Assert reset mid-BURST → outputs return to 4'b0001 immediately.
